// File: rtl/sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// sb_tx_arbiter
// Round-robin, packet-locked arbiter that lets N switchboard requesters share
// one TX queue writer. Once a requester wins, it keeps the grant until its
// last beat is accepted, so packets never interleave downstream. A single
// registered slot sits between the arbiter and the queue writer.
//
// Parameters
//   N   number of requester ports (1..16)
//   DW  payload width per beat (<= 448)
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   en                    allow new grants (a locked packet always completes)
//   in_data/in_dest       per-port payload and destination, port i at slice i
//   in_last/in_valid      per-port end-of-packet and beat-valid
//   in_ready              per-port beat accepted when valid & ready
//   out_data/out_dest     registered beat towards the queue writer
//   out_last/out_valid    registered end-of-packet and beat-valid
//   out_ready             queue writer can take the beat
//   status_idle           unlocked and output slot empty
//   status_owner          current or most recently granted port
//   status_locked         a packet is in progress
//   pkt_count             packets handed downstream (wrapping)
// ---------------------------------------------------------------------------
module sb_tx_arbiter #(
   parameter int N  = 4,
   parameter int DW = 416,
   localparam int OW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [N*DW-1:0] in_data,
   input  logic [N*32-1:0] in_dest,
   input  logic [N-1:0]    in_last,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [DW-1:0]   out_data,
   output logic [31:0]     out_dest,
   output logic            out_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            status_idle,
   output logic [OW-1:0]   status_owner,
   output logic            status_locked,
   output logic [31:0]     pkt_count
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   rrPtr_q, rrPtr_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [DW-1:0]   outData_q, outData_d;
   logic [31:0]     outDest_q, outDest_d;
   logic            outLast_q, outLast_d;
   logic            outValid_q, outValid_d;
   logic [31:0]     pktCount_q, pktCount_d;

   logic            slotFree;
   logic            grantValid;
   logic [OW-1:0]   grantIdx;
   logic [OW-1:0]   scanIdx;
   logic [OW:0]     scanSum;
   logic            accept;
   logic [DW-1:0]   selData;
   logic [31:0]     selDest;
   logic            selLast;
   logic            selValid;
   logic [OW-1:0]   rrNext;

   assign slotFree = !outValid_q || out_ready;

   // Pick the port that may see ready this cycle. While locked only the owner
   // is eligible, whether or not it is currently presenting a beat. While
   // unlocked, the first valid port at or after rrPtr wins, provided en is set.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      scanIdx    = '0;
      scanSum    = '0;
      if (state_q == LOCKED) begin
         grantValid = 1'b1;
         grantIdx   = owner_q;
      end else if (en) begin
         for (int k = 0; k < N; k++) begin
            scanSum = {1'b0, rrPtr_q} + (OW+1)'(k);
            if (scanSum >= (OW+1)'(N)) begin
               scanSum = scanSum - (OW+1)'(N);
            end
            scanIdx = scanSum[OW-1:0];
            if (!grantValid && in_valid[scanIdx]) begin
               grantValid = 1'b1;
               grantIdx   = scanIdx;
            end
         end
      end
   end

   // Steer the granted port's beat towards the slot and raise its ready.
   // No handshake may complete while reset is held, so ready is forced low.
   always_comb begin
      selData  = '0;
      selDest  = '0;
      selLast  = 1'b0;
      selValid = 1'b0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (OW'(i) == grantIdx) begin
            selData  = in_data[i*DW +: DW];
            selDest  = in_dest[i*32 +: 32];
            selLast  = in_last[i];
            selValid = in_valid[i];
         end
      end
      if (grantValid && slotFree && !reset) begin
         in_ready[grantIdx] = 1'b1;
      end
   end

   assign accept = grantValid && slotFree && selValid && !reset;
   assign rrNext = (grantIdx == OW'(N-1)) ? '0 : grantIdx + OW'(1);

   // Next-state for the lock FSM, the round-robin pointer, the output slot
   // and the packet counter. A drain and a load can happen in the same cycle,
   // which is what gives one beat per cycle with out_ready held high.
   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      owner_d    = owner_q;
      outData_d  = outData_q;
      outDest_d  = outDest_q;
      outLast_d  = outLast_q;
      outValid_d = outValid_q;
      pktCount_d = pktCount_q;
      if (outValid_q && out_ready && outLast_q) begin
         pktCount_d = pktCount_q + 32'd1;
      end
      if (accept) begin
         outData_d  = selData;
         outDest_d  = selDest;
         outLast_d  = selLast;
         outValid_d = 1'b1;
         owner_d    = grantIdx;
         if (selLast) begin
            state_d = UNLOCKED;
            rrPtr_d = rrNext;
         end else begin
            state_d = LOCKED;
         end
      end else if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // State register; reset drops any lock and discards a beat in the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         rrPtr_q    <= '0;
         owner_q    <= '0;
         outData_q  <= '0;
         outDest_q  <= '0;
         outLast_q  <= 1'b0;
         outValid_q <= 1'b0;
         pktCount_q <= '0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         owner_q    <= owner_d;
         outData_q  <= outData_d;
         outDest_q  <= outDest_d;
         outLast_q  <= outLast_d;
         outValid_q <= outValid_d;
         pktCount_q <= pktCount_d;
      end
   end

   assign out_data      = outData_q;
   assign out_dest      = outDest_q;
   assign out_last      = outLast_q;
   assign out_valid     = outValid_q;
   assign status_idle   = (state_q == UNLOCKED) && !outValid_q;
   assign status_locked = (state_q == LOCKED);
   assign status_owner  = owner_q;
   assign pkt_count     = pktCount_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sb_tx_arbiter
// Directed, self-checking bench for sb_tx_arbiter with N=4, DW=416. Each
// scenario task drives its own stimulus and compares against hand-computed
// expectations; the tasks run in sequence and carry arbiter state (round-robin
// pointer, packet count) from one to the next.
// ---------------------------------------------------------------------------
module tb_sb_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 416;
   localparam int OW = 2;

   logic            clk;
   logic            reset;
   logic            en;
   logic [N*DW-1:0] in_data;
   logic [N*32-1:0] in_dest;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic [31:0]     out_dest;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;
   logic            status_idle;
   logic [OW-1:0]   status_owner;
   logic            status_locked;
   logic [31:0]     pkt_count;

   int testsRun    = 0;
   int testsFailed = 0;

   sb_tx_arbiter #(.N(N), .DW(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .in_data       (in_data),
      .in_dest       (in_dest),
      .in_last       (in_last),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_dest      (out_dest),
      .out_last      (out_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .status_idle   (status_idle),
      .status_owner  (status_owner),
      .status_locked (status_locked),
      .pkt_count     (pkt_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Unique destination per (port, beat) so the output stream identifies its source.
   function automatic logic [31:0] destOf(input int p, input int b);
      return 32'hA500_0000 | 32'(p << 8) | 32'(b);
   endfunction

   // Payload marks both ends of the beat so a mis-steered slice is visible.
   function automatic logic [DW-1:0] dataOf(input int p, input int b);
      logic [DW-1:0] d;
      d = '0;
      d[31:0]      = 32'hDA7A_0000 | 32'(p << 8) | 32'(b);
      d[DW-1 -: 32] = ~d[31:0];
      return d;
   endfunction

   // Advance one clock; sampling happens 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setPort(input int p, input bit v, input bit l, input int b);
      in_valid[p]          = v;
      in_last[p]           = l;
      in_dest[p*32 +: 32]  = destOf(p, b);
      in_data[p*DW +: DW]  = dataOf(p, b);
   endtask

   // Reset values, with requesters valid to show ready stays low in reset.
   task automatic test_reset();
      reset     = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      in_data   = '0;
      in_dest   = '0;
      in_last   = '0;
      in_valid  = '1;
      step();
      step();
      testsRun++;
      if (in_ready !== 4'b0000) begin
         testsFailed++; $display("[TB] FAIL reset_in_ready got %b expected 0000", in_ready);
      end
      testsRun++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_dest !== 32'h0 || out_data !== '0) begin
         testsFailed++; $display("[TB] FAIL reset_out got valid=%b last=%b dest=%h expected all zero", out_valid, out_last, out_dest);
      end
      testsRun++;
      if (pkt_count !== 32'd0 || status_idle !== 1'b1 || status_owner !== 2'd0 || status_locked !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_status got cnt=%0d idle=%b owner=%0d locked=%b expected 0/1/0/0", pkt_count, status_idle, status_owner, status_locked);
      end
      in_valid = '0;
      reset    = 1'b0;
      step();
   endtask

   // All ports valid with single-beat packets: grants rotate 0,1,2,3,0.
   task automatic test_round_robin();
      logic [3:0] expReady;
      int p;
      for (int i = 0; i < N; i++) setPort(i, 1'b1, 1'b1, 0);
      for (int k = 0; k < 5; k++) begin
         p = k % N;
         expReady = 4'(1 << p);
         #1;
         testsRun++;
         if (in_ready !== expReady) begin
            testsFailed++; $display("[TB] FAIL rr_ready%0d got %b expected %b", k, in_ready, expReady);
         end
         step();
         testsRun++;
         if (out_valid !== 1'b1 || out_dest !== destOf(p, 0) || out_data !== dataOf(p, 0) || out_last !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL rr_out%0d got valid=%b dest=%h expected 1/%h", k, out_valid, out_dest, destOf(p, 0));
         end
         testsRun++;
         if (pkt_count !== 32'(k) || status_owner !== 2'(p)) begin
            testsFailed++; $display("[TB] FAIL rr_cnt%0d got cnt=%0d owner=%0d expected %0d/%0d", k, pkt_count, status_owner, k, p);
         end
      end
      in_valid = '0;
      step();
      testsRun++;
      if (pkt_count !== 32'd5 || out_valid !== 1'b0 || status_idle !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL rr_final got cnt=%0d valid=%b idle=%b expected 5/0/1", pkt_count, out_valid, status_idle);
      end
   endtask

   // Port 1 sends a 3-beat packet while port 2 waits; port 2 follows with no bubble.
   task automatic test_packet_lock();
      setPort(1, 1'b1, 1'b0, 0);
      setPort(2, 1'b1, 1'b1, 0);
      for (int b = 0; b < 3; b++) begin
         if (b > 0) setPort(1, 1'b1, (b == 2), b);
         #1;
         testsRun++;
         if (in_ready !== 4'b0010) begin
            testsFailed++; $display("[TB] FAIL lock_ready%0d got %b expected 0010", b, in_ready);
         end
         step();
         testsRun++;
         if (out_dest !== destOf(1, b) || status_owner !== 2'd1 || status_locked !== (b != 2)) begin
            testsFailed++; $display("[TB] FAIL lock_out%0d got dest=%h locked=%b expected %h/%b", b, out_dest, status_locked, destOf(1, b), (b != 2));
         end
      end
      setPort(1, 1'b0, 1'b0, 0);
      #1;
      testsRun++;
      if (in_ready !== 4'b0100) begin
         testsFailed++; $display("[TB] FAIL lock_next_ready got %b expected 0100", in_ready);
      end
      step();
      testsRun++;
      if (out_dest !== destOf(2, 0) || out_valid !== 1'b1 || status_owner !== 2'd2 || pkt_count !== 32'd6) begin
         testsFailed++; $display("[TB] FAIL lock_next_out got dest=%h cnt=%0d expected %h/6", out_dest, pkt_count, destOf(2, 0));
      end
      setPort(2, 1'b0, 1'b0, 0);
      step();
      testsRun++;
      if (pkt_count !== 32'd7) begin
         testsFailed++; $display("[TB] FAIL lock_cnt got %0d expected 7", pkt_count);
      end
   endtask

   // Owner port 0 stalls mid-packet; port 3 must wait for port 0's last beat.
   task automatic test_owner_stall();
      setPort(0, 1'b1, 1'b0, 0);
      #1;
      testsRun++;
      if (in_ready !== 4'b0001) begin
         testsFailed++; $display("[TB] FAIL stall_first_ready got %b expected 0001", in_ready);
      end
      step();
      setPort(0, 1'b0, 1'b0, 0);
      setPort(3, 1'b1, 1'b1, 0);
      for (int c = 0; c < 4; c++) begin
         #1;
         testsRun++;
         if (in_ready !== 4'b0001 || status_locked !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL stall_hold%0d got ready=%b locked=%b expected 0001/1", c, in_ready, status_locked);
         end
         step();
      end
      setPort(0, 1'b1, 1'b1, 1);
      #1;
      step();
      testsRun++;
      if (out_dest !== destOf(0, 1) || status_locked !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL stall_last got dest=%h locked=%b expected %h/0", out_dest, status_locked, destOf(0, 1));
      end
      setPort(0, 1'b0, 1'b0, 0);
      #1;
      testsRun++;
      if (in_ready !== 4'b1000) begin
         testsFailed++; $display("[TB] FAIL stall_p3_ready got %b expected 1000", in_ready);
      end
      step();
      testsRun++;
      if (out_dest !== destOf(3, 0)) begin
         testsFailed++; $display("[TB] FAIL stall_p3_out got %h expected %h", out_dest, destOf(3, 0));
      end
      setPort(3, 1'b0, 1'b0, 0);
      step();
      testsRun++;
      if (pkt_count !== 32'd9) begin
         testsFailed++; $display("[TB] FAIL stall_cnt got %0d expected 9", pkt_count);
      end
   endtask

   // Downstream stalls 5 cycles with the slot full, then drains and reloads together.
   task automatic test_backpressure();
      setPort(1, 1'b1, 1'b1, 4);
      #1;
      step();
      out_ready = 1'b0;
      setPort(1, 1'b1, 1'b1, 5);
      setPort(2, 1'b1, 1'b1, 4);
      for (int c = 0; c < 5; c++) begin
         #1;
         testsRun++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_dest !== destOf(1, 4) || out_data !== dataOf(1, 4)) begin
            testsFailed++; $display("[TB] FAIL bp_hold%0d got ready=%b valid=%b dest=%h expected 0000/1/%h", c, in_ready, out_valid, out_dest, destOf(1, 4));
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      testsRun++;
      if (in_ready !== 4'b0100) begin
         testsFailed++; $display("[TB] FAIL bp_release_ready got %b expected 0100", in_ready);
      end
      step();
      testsRun++;
      if (out_dest !== destOf(2, 4) || out_valid !== 1'b1 || pkt_count !== 32'd10) begin
         testsFailed++; $display("[TB] FAIL bp_reload got dest=%h cnt=%0d expected %h/10", out_dest, pkt_count, destOf(2, 4));
      end
      setPort(2, 1'b0, 1'b0, 0);
      #1;
      testsRun++;
      if (in_ready !== 4'b0010) begin
         testsFailed++; $display("[TB] FAIL bp_p1_ready got %b expected 0010", in_ready);
      end
      step();
      setPort(1, 1'b0, 1'b0, 0);
      step();
      testsRun++;
      if (pkt_count !== 32'd12 || out_valid !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL bp_cnt got cnt=%0d valid=%b expected 12/0", pkt_count, out_valid);
      end
   endtask

   // en low blocks new grants but never cuts a locked packet short.
   task automatic test_enable();
      en = 1'b0;
      setPort(0, 1'b1, 1'b0, 6);
      setPort(3, 1'b1, 1'b0, 6);
      for (int c = 0; c < 3; c++) begin
         #1;
         testsRun++;
         if (in_ready !== 4'b0000 || status_idle !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL en_block%0d got ready=%b idle=%b expected 0000/1", c, in_ready, status_idle);
         end
         step();
      end
      en = 1'b1;
      #1;
      testsRun++;
      if (in_ready !== 4'b1000) begin
         testsFailed++; $display("[TB] FAIL en_grant got %b expected 1000", in_ready);
      end
      step();
      en = 1'b0;
      setPort(3, 1'b1, 1'b1, 7);
      #1;
      testsRun++;
      if (in_ready !== 4'b1000 || status_locked !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL en_locked got ready=%b locked=%b expected 1000/1", in_ready, status_locked);
      end
      step();
      setPort(3, 1'b0, 1'b0, 0);
      for (int c = 0; c < 2; c++) begin
         #1;
         testsRun++;
         if (in_ready !== 4'b0000) begin
            testsFailed++; $display("[TB] FAIL en_after%0d got %b expected 0000", c, in_ready);
         end
         step();
      end
      testsRun++;
      if (pkt_count !== 32'd13 || status_idle !== 1'b1 || out_dest !== destOf(3, 7)) begin
         testsFailed++; $display("[TB] FAIL en_final got cnt=%0d idle=%b dest=%h expected 13/1/%h", pkt_count, status_idle, out_dest, destOf(3, 7));
      end
   endtask

   // Reset mid-packet with a full slot; afterwards arbitration restarts at port 0.
   task automatic test_reset_mid_packet();
      en        = 1'b1;
      out_ready = 1'b0;
      setPort(2, 1'b1, 1'b0, 8);
      #1;
      testsRun++;
      if (in_ready !== 4'b0001) begin
         testsFailed++; $display("[TB] FAIL rst_pre_ready got %b expected 0001", in_ready);
      end
      step();
      testsRun++;
      if (status_locked !== 1'b1 || out_valid !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL rst_pre_state got locked=%b valid=%b expected 1/1", status_locked, out_valid);
      end
      reset = 1'b1;
      #1;
      testsRun++;
      if (out_valid !== 1'b0 || pkt_count !== 32'd0 || status_locked !== 1'b0 || in_ready !== 4'b0000) begin
         testsFailed++; $display("[TB] FAIL rst_async got valid=%b cnt=%0d locked=%b ready=%b expected 0/0/0/0000", out_valid, pkt_count, status_locked, in_ready);
      end
      step();
      reset = 1'b0;
      #1;
      testsRun++;
      if (in_ready !== 4'b0001) begin
         testsFailed++; $display("[TB] FAIL rst_restart_ready got %b expected 0001", in_ready);
      end
      out_ready = 1'b1;
      step();
      testsRun++;
      if (out_dest !== destOf(0, 6) || status_owner !== 2'd0) begin
         testsFailed++; $display("[TB] FAIL rst_restart_out got dest=%h owner=%0d expected %h/0", out_dest, status_owner, destOf(0, 6));
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_owner_stall();
      test_backpressure();
      test_enable();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
